// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus arbiter.
// Contents: arbiter state encoding, active-low level constants and the
// bus-idle test used by the FSM.
package pci_pkg;

  typedef enum logic [1:0] {
    PARK    = 2'd0,
    SWITCH  = 2'd1,
    GRANTED = 2'd2,
    BUSY    = 2'd3
  } arb_state_e;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  // The bus is idle when neither FRAME nor IRDY is driven low.
  function automatic logic bus_idle(input logic frame_l, input logic irdy_l);
    return (frame_l == DEASSERTED) && (irdy_l == DEASSERTED);
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin priority search.
// Ports:
//   req_act - active-high request vector (one bit per master)
//   ptr     - round-robin pointer; search starts at ptr+1 and ptr is last
//   winner  - index of the first requesting master found (ptr if none)
//   valid   - 1 when at least one request is present
module pci_rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_act,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  // Walk offsets 1..N from ptr; offset N wraps back onto ptr itself.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!valid && req_act[IW'((32'(ptr) + k) % N)]) begin
        winner = IW'((32'(ptr) + k) % N);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin REQ/GNT arbitration with hidden
// pre-arbitration, bus parking and a grant timeout. Observes FRAME/IRDY only.
// Ports:
//   clk      - bus clock, all logic on posedge
//   reset    - synchronous active-low reset
//   frame    - PCI FRAME (active-low), sampled
//   irdy     - PCI IRDY (active-low), sampled
//   req      - per-master request (active-low)
//   gnt      - per-master grant (active-low), registered
//   owner    - index of current/last grantee, registered
//   bus_busy - 1 while a transaction is in progress, registered
module pci_arbiter
  import pci_pkg::*;
#(
  parameter  int unsigned N_MASTERS     = 4,
  parameter  int unsigned PARK_MASTER   = 0,
  parameter  int unsigned GRANT_TIMEOUT = 16,
  localparam int unsigned IW            = $clog2(N_MASTERS),
  localparam int unsigned CW            = $clog2(GRANT_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame,
  input  logic                 irdy,
  input  logic [N_MASTERS-1:0] req,
  output logic [N_MASTERS-1:0] gnt,
  output logic [IW-1:0]        owner,
  output logic                 bus_busy
);

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] gnt_d;
  logic [IW-1:0]        owner_d;
  logic                 busy_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        latch_q, latch_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 prev_idle_q;

  logic                 idle;
  logic [N_MASTERS-1:0] req_act;
  logic                 owner_req;
  logic                 others_req;
  logic                 frame_start;
  logic                 timeout;
  logic [IW-1:0]        pick_ptr;
  logic [IW-1:0]        pick_winner;
  logic                 pick_valid;
  logic [IW-1:0]        pick_or_park;

  function automatic logic [N_MASTERS-1:0] grant_for(input logic [IW-1:0] idx);
    return ~(N_MASTERS'(1) << idx);
  endfunction

  // Request/bus decode shared by all states.
  always_comb begin
    idle        = bus_idle(frame, irdy);
    req_act     = ~req;
    owner_req   = req_act[owner];
    others_req  = |(req_act & ~(N_MASTERS'(1) << owner));
    // A start only counts after an idle sample, so a pre-granted master
    // cannot be confused with the tail of the previous transaction.
    frame_start = (frame == ASSERTED) && prev_idle_q;
    cnt_inc     = (cnt_q == CW'(GRANT_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    timeout     = (state_q == GRANTED) && idle && (cnt_inc == CW'(GRANT_TIMEOUT));
    // On timeout the owner becomes the pointer so it is searched last.
    pick_ptr    = timeout ? owner : rr_q;
  end

  pci_rr_picker #(.N(N_MASTERS)) u_picker (
    .req_act (req_act),
    .ptr     (pick_ptr),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  assign pick_or_park = pick_valid ? pick_winner : IW'(PARK_MASTER);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    owner_d = owner;
    busy_d  = bus_busy;
    rr_d    = rr_q;
    latch_d = latch_q;
    cnt_d   = '0;

    // Outside BUSY, two idle samples in a row mean nothing is running.
    if (state_q != BUSY && idle && prev_idle_q) busy_d = 1'b0;

    case (state_q)
      PARK: begin
        if (pick_valid) begin
          if (pick_winner == owner) begin
            state_d = GRANTED;
          end else begin
            state_d = SWITCH;
            gnt_d   = '1;
            latch_d = pick_winner;
          end
        end
      end

      SWITCH: begin
        if (req_act[latch_q]) begin
          state_d = GRANTED;
          owner_d = latch_q;
          gnt_d   = grant_for(latch_q);
        end else if (pick_valid) begin
          state_d = GRANTED;
          owner_d = pick_winner;
          gnt_d   = grant_for(pick_winner);
        end else begin
          state_d = PARK;
          owner_d = IW'(PARK_MASTER);
          gnt_d   = grant_for(IW'(PARK_MASTER));
        end
      end

      GRANTED: begin
        if (frame_start) begin
          state_d = BUSY;
          busy_d  = 1'b1;
          rr_d    = owner;
        end else if (timeout) begin
          state_d = SWITCH;
          gnt_d   = '1;
          rr_d    = owner;
          latch_d = pick_or_park;
        end else if (!owner_req && frame == DEASSERTED) begin
          state_d = SWITCH;
          gnt_d   = '1;
          latch_d = pick_or_park;
        end else begin
          cnt_d = idle ? cnt_inc : cnt_q;
        end
      end

      BUSY: begin
        if (idle) begin
          busy_d = 1'b0;
          if (pick_valid) begin
            if (pick_winner == owner) begin
              state_d = GRANTED;
            end else begin
              state_d = SWITCH;
              gnt_d   = '1;
              latch_d = pick_winner;
            end
          end else if (owner == IW'(PARK_MASTER)) begin
            state_d = PARK;
          end else begin
            state_d = SWITCH;
            gnt_d   = '1;
            latch_d = IW'(PARK_MASTER);
          end
        end else if (others_req) begin
          // Hidden arbitration: hand the grant over while the bus is busy.
          state_d = SWITCH;
          gnt_d   = '1;
          latch_d = pick_winner;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset == ASSERTED) begin
      state_q     <= SWITCH;
      gnt         <= '1;
      owner       <= IW'(PARK_MASTER);
      bus_busy    <= 1'b0;
      rr_q        <= IW'(PARK_MASTER);
      latch_q     <= IW'(PARK_MASTER);
      cnt_q       <= '0;
      prev_idle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt         <= gnt_d;
      owner       <= owner_d;
      bus_busy    <= busy_d;
      rr_q        <= rr_d;
      latch_q     <= latch_d;
      cnt_q       <= cnt_d;
      prev_idle_q <= idle;
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter (4 masters, park on 0, timeout 16).
// Inputs change on the falling edge; outputs are checked on the next
// falling edge, i.e. after the rising edge that sampled those inputs.
module tb_pci_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame;
  logic       irdy;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       bus_busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] prev_gnt = 4'b1111;

  typedef struct {
    logic       rst;
    logic       fr;
    logic       ir;
    logic [3:0] rq;
    logic [3:0] eg;
    logic [1:0] eo;
    logic       eb;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  pci_arbiter #(
    .N_MASTERS     (4),
    .PARK_MASTER   (0),
    .GRANT_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .frame    (frame),
    .irdy     (irdy),
    .req      (req),
    .gnt      (gnt),
    .owner    (owner),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rs, input logic fr, input logic ir,
                     input logic [3:0] rq, input logic [3:0] eg,
                     input logic [1:0] eo, input logic eb, input string nm);
    vec_t v;
    v.rst = rs; v.fr = fr; v.ir = ir; v.rq = rq;
    v.eg = eg; v.eo = eo; v.eb = eb; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rs, input logic fr, input logic ir,
                      input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] eo, input logic eb, input string nm);
    reset = rs; frame = fr; irdy = ir; req = rq;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL %s gnt got %b want %b", nm, gnt, eg);
    end
    checks++;
    if (owner !== eo) begin
      errors++;
      $display("FAIL %s owner got %0d want %0d", nm, owner, eo);
    end
    checks++;
    if (bus_busy !== eb) begin
      errors++;
      $display("FAIL %s bus_busy got %b want %b", nm, bus_busy, eb);
    end
    checks++;
    if ($countones(~gnt) > 1) begin
      errors++;
      $display("FAIL %s onehot gnt got %b want at most one low", nm, gnt);
    end
    checks++;
    if (prev_gnt != 4'b1111 && gnt != 4'b1111 && gnt != prev_gnt) begin
      errors++;
      $display("FAIL %s handover gnt got %b after %b want 1111 between", nm, gnt, prev_gnt);
    end
    prev_gnt = gnt;
  endtask

  initial begin
    reset = 1'b0; frame = 1'b1; irdy = 1'b1; req = 4'b1111;

    // Reset, then park on master 0.
    add(0, 1, 1, 4'b1111, 4'b1111, 0, 0, "rst0");
    add(0, 1, 1, 4'b1111, 4'b1111, 0, 0, "rst1");
    add(1, 1, 1, 4'b1111, 4'b1110, 0, 0, "park_after_rst");
    // Master 1 single 3-beat write, then re-park.
    add(1, 1, 1, 4'b1101, 4'b1111, 0, 0, "s2_switch");
    add(1, 1, 1, 4'b1101, 4'b1101, 1, 0, "s2_gnt1");
    add(1, 1, 1, 4'b1101, 4'b1101, 1, 0, "s2_wait");
    add(1, 0, 0, 4'b1101, 4'b1101, 1, 1, "s2_start");
    add(1, 0, 0, 4'b1111, 4'b1101, 1, 1, "s2_beat2");
    add(1, 1, 0, 4'b1111, 4'b1101, 1, 1, "s2_beat3");
    add(1, 1, 1, 4'b1111, 4'b1111, 1, 0, "s2_idle_switch");
    add(1, 1, 1, 4'b1111, 4'b1110, 0, 0, "s2_repark");
    // Everyone requesting: grant order 1,2,3,0,1.
    add(0, 1, 1, 4'b1111, 4'b1111, 0, 0, "s3_rst");
    add(1, 1, 1, 4'b1111, 4'b1110, 0, 0, "s3_park");
    add(1, 1, 1, 4'b0000, 4'b1111, 0, 0, "s3_sw1");
    add(1, 1, 1, 4'b0000, 4'b1101, 1, 0, "s3_gnt1");
    add(1, 0, 0, 4'b0000, 4'b1101, 1, 1, "s3_m1_start");
    add(1, 1, 0, 4'b0000, 4'b1111, 1, 1, "s3_sw2");
    add(1, 1, 1, 4'b0000, 4'b1011, 2, 1, "s3_gnt2");
    add(1, 0, 0, 4'b0000, 4'b1011, 2, 1, "s3_m2_start");
    add(1, 1, 0, 4'b0000, 4'b1111, 2, 1, "s3_sw3");
    add(1, 1, 1, 4'b0000, 4'b0111, 3, 1, "s3_gnt3");
    add(1, 0, 0, 4'b0000, 4'b0111, 3, 1, "s3_m3_start");
    add(1, 1, 0, 4'b0000, 4'b1111, 3, 1, "s3_sw0");
    add(1, 1, 1, 4'b0000, 4'b1110, 0, 1, "s3_gnt0");
    add(1, 0, 0, 4'b0000, 4'b1110, 0, 1, "s3_m0_start");
    add(1, 1, 0, 4'b0000, 4'b1111, 0, 1, "s3_sw1b");
    add(1, 1, 1, 4'b0000, 4'b1101, 1, 1, "s3_gnt1b");
    add(1, 1, 1, 4'b1111, 4'b1111, 1, 0, "s3_revoke");
    add(1, 1, 1, 4'b1111, 4'b1110, 0, 0, "s3_repark");
    // Master 2 6-beat burst, master 3 pre-granted, one idle cycle between.
    add(1, 1, 1, 4'b1011, 4'b1111, 0, 0, "s4_sw2");
    add(1, 1, 1, 4'b1011, 4'b1011, 2, 0, "s4_gnt2");
    add(1, 0, 0, 4'b1011, 4'b1011, 2, 1, "s4_m2_start");
    add(1, 0, 0, 4'b0111, 4'b1111, 2, 1, "s4_pregrant_sw");
    add(1, 0, 0, 4'b0111, 4'b0111, 3, 1, "s4_gnt3_busy");
    add(1, 0, 0, 4'b0111, 4'b0111, 3, 1, "s4_m3_held1");
    add(1, 0, 0, 4'b0111, 4'b0111, 3, 1, "s4_m3_held2");
    add(1, 1, 0, 4'b0111, 4'b0111, 3, 1, "s4_m2_last");
    add(1, 1, 1, 4'b0111, 4'b0111, 3, 1, "s4_gap");
    add(1, 0, 0, 4'b0111, 4'b0111, 3, 1, "s4_m3_start");
    add(1, 1, 0, 4'b1111, 4'b0111, 3, 1, "s4_m3_last");
    add(1, 1, 1, 4'b1111, 4'b1111, 3, 0, "s4_idle_switch");
    add(1, 1, 1, 4'b1111, 4'b1110, 0, 0, "s4_repark");

    @(negedge clk);
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].fr, vecs[i].ir, vecs[i].rq,
           vecs[i].eg, vecs[i].eo, vecs[i].eb, vecs[i].nm);

    // Master 1 granted but silent while master 2 waits: revoked after 16 idle cycles.
    step(1, 1, 1, 4'b1101, 4'b1111, 0, 0, "s5_sw1");
    step(1, 1, 1, 4'b1101, 4'b1101, 1, 0, "s5_gnt1");
    for (int i = 0; i < 15; i++)
      step(1, 1, 1, 4'b1001, 4'b1101, 1, 0, "s5_wait");
    step(1, 1, 1, 4'b1001, 4'b1111, 1, 0, "s5_timeout");
    step(1, 1, 1, 4'b1001, 4'b1011, 2, 0, "s5_gnt2");

    // Reset in the middle of a master 2 burst.
    step(1, 0, 0, 4'b1011, 4'b1011, 2, 1, "s6_m2_start");
    step(1, 0, 0, 4'b1011, 4'b1011, 2, 1, "s6_burst");
    step(0, 0, 0, 4'b1011, 4'b1111, 0, 0, "s6_reset_mid");
    step(1, 1, 1, 4'b1111, 4'b1110, 0, 0, "s6_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_arbiter.md
Name: pci_arbiter

Overview:
- Central PCI bus arbiter that shares the FRAME/IRDY/AD bus among N initiators using per-master REQ/GNT pairs.
- Round-robin fairness, hidden (pre-)arbitration during busy transactions, bus parking when no one requests, and a grant timeout for masters that never start.
- Sits beside the slave target on the shared bus; watches FRAME/IRDY only and never drives the bus itself.

Parameters:
- N_MASTERS, 4, number of initiators (2..8).
- PARK_MASTER, 0, index granted when no REQ is asserted.
- GRANT_TIMEOUT, 16, idle-bus cycles a granted master has to assert FRAME before its grant is revoked.

Ports:
- CLK  input  1  bus clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- FRAME  input  1  PCI FRAME, active-low, sampled only.
- IRDY  input  1  PCI IRDY, active-low, sampled only.
- REQ  input  N_MASTERS  per-master request, active-low.
- GNT  output  N_MASTERS  per-master grant, active-low, registered.
- OWNER  output  clog2(N_MASTERS)  index of the current or last grantee, registered.
- BUS_BUSY  output  1  registered; 1 while a transaction is in progress.

Behaviour:
- Bus idle: FRAME==1 && IRDY==1, sampled at posedge.
- Reset (reset==0 at posedge): GNT all 1s, OWNER=PARK_MASTER, BUS_BUSY=0, rr pointer=PARK_MASTER, timeout counter=0, state=SWITCH.
  - With no REQ, GNT[PARK_MASTER] goes low on the 1st edge after reset release.
  - Reset mid-transaction drops all grants on the same edge.
- Invariant: at most one GNT bit is low in any cycle.
- Invariant: every change of grantee passes through exactly one cycle with GNT all 1s (SWITCH).
- Winner selection: first asserted REQ searching from (rr pointer+1) mod N upward, wrapping; the rr pointer itself is searched last.
- States:
  - PARK: GNT low for OWNER, no REQ pending. Any REQ low -> compute winner.
    - winner==OWNER -> GRANTED, GNT unchanged.
    - otherwise -> SWITCH.
  - SWITCH: GNT all 1s for one cycle, then GNT[winner] low, OWNER=winner.
    - winner = latched request; if no REQ remains, PARK_MASTER.
    - Next state GRANTED if a request exists, else PARK.
  - GRANTED: grant held, waiting for the owner to start.
    - FRAME sampled 0 while the bus was idle the previous cycle -> BUSY, BUS_BUSY=1, rr pointer=OWNER, counter cleared.
    - Owner REQ high and FRAME high -> revoke: SWITCH to the next winner, or PARK_MASTER.
    - Counter increments each idle cycle; at GRANT_TIMEOUT -> rr pointer=OWNER, SWITCH (the owner loses its turn).
  - BUSY: transaction in progress.
    - Another master requesting -> pre-grant: SWITCH, then GNT to the new winner while still busy; the new owner waits in GRANTED for idle.
    - No other request -> grant stays with OWNER.
    - On idle: BUS_BUSY=0; REQ pending -> GRANTED/SWITCH per the winner rule, else PARK with OWNER kept when OWNER==PARK_MASTER, otherwise SWITCH to PARK_MASTER.
- In GRANTED, a FRAME start is recognised only after idle is observed, so a pre-granted master never collides with the ending transaction.
- Simultaneous events:
  - FRAME falls in the same cycle the owner drops REQ, or the timeout expires: the transaction wins -> BUSY.
  - All REQ deassert during SWITCH: park on PARK_MASTER.
- Counter width: clog2(GRANT_TIMEOUT+1). It saturates and cannot wrap.

Decomposition:
- Shared package pci_pkg holds:
  - the state enum (PARK, SWITCH, GRANTED, BUSY);
  - the active-low constants ASSERTED=1'b0 and DEASSERTED=1'b1;
  - the bus-idle helper function.
- One sub-module, pci_rr_picker: combinational round-robin priority search (req vector and pointer in; winner index and valid out).
- The FSM, timeout counter and registered outputs stay in pci_arbiter.

Test Plan:
All scenarios use N_MASTERS=4, PARK_MASTER=0, GRANT_TIMEOUT=16.
1. Reset low for 2 cycles, no REQ -> GNT=1111 during reset, GNT=1110 one cycle after release, OWNER=0, BUS_BUSY=0.
2. REQ=1101 (master 1); master 1 drives FRAME low 2 cycles after GNT, 3-beat write with IRDY low, then FRAME/IRDY high.
   - GNT 1110 -> 1111 (one cycle) -> 1101.
   - BUS_BUSY=1 from the edge after FRAME low until idle.
   - After REQ released, parks back via 1111 -> 1110.
3. REQ=0000 held, each master runs one transaction on grant -> grant order 1, 2, 3, 0, 1.
   - Every handover shows one 1111 cycle.
   - Never two GNT bits low together.
4. Master 2 in a 6-cycle burst while master 3 asserts REQ -> GNT 1011 -> 1111 -> 0111 during the burst.
   - Master 3 FRAME is accepted only after FRAME=1/IRDY=1 is seen.
   - BUS_BUSY stays 1 across back-to-back transactions with one idle cycle.
5. Master 1 granted but never asserts FRAME while master 2 requests -> after 16 idle cycles GNT 1101 -> 1111 -> 1011.
   - rr pointer=1, so master 2 is served before master 1 again.
6. Reset asserted in the middle of the scenario-4 burst -> GNT=1111 on the same edge, BUS_BUSY=0, OWNER=0.
   - On release with no REQ, GNT=1110.
